// File: rtl/idu_issue_ctrl.sv
// Decode-stage issue controller: 2-entry skid buffer between IFU and EXU with
// one-hot format decode on enqueue. Optional perf counters under IDU_PERF_EN.
module idu_issue_ctrl #(
  parameter int XLEN   = 32,
  parameter int TYPE_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   in_inst_i,
  input  logic [XLEN-1:0]   in_pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_inst_o,
  output logic [XLEN-1:0]   out_pc_o,
  output logic [TYPE_W-1:0] type_o,
  output logic [TYPE_W-2:0] imm_sel_o,
  output logic              illegal_o,
  output logic [31:0]       perf_issue_o,
  output logic [31:0]       perf_stall_o
);

  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, TWO = 2'b11} state_e;

  logic              head_valid, skid_valid;
  logic [XLEN-1:0]   head_inst, head_pc, skid_inst, skid_pc;
  logic [TYPE_W-1:0] head_type, skid_type, in_type;
  logic              head_ill, skid_ill, in_ill;
  logic              enq, deq;
  state_e            state;

  function automatic logic [TYPE_W:0] decode(input logic [6:0] op);
    logic [TYPE_W-1:0] t;
    t = '0;
    case (op)
      7'b0110011, 7'b0111011:                                  t[0] = 1'b1;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: t[1] = 1'b1;
      7'b0100011:                                              t[2] = 1'b1;
      7'b1100011:                                              t[3] = 1'b1;
      7'b0110111, 7'b0010111:                                  t[4] = 1'b1;
      7'b1101111:                                              t[5] = 1'b1;
      default:                                                 t    = '0;
    endcase
    // Every recognised opcode ends in 2'b11, so compressed encodings fall out as illegal.
    return {(t == '0), t};
  endfunction

  assign {in_ill, in_type} = decode(in_inst_i[6:0]);
  assign state             = state_e'({head_valid, skid_valid});

  assign in_ready_o  = ~skid_valid;
  assign enq         = in_valid_i & in_ready_o;
  assign deq         = head_valid & out_ready_i;

  assign out_valid_o = head_valid;
  assign out_inst_o  = head_inst;
  assign out_pc_o    = head_pc;
  assign type_o      = head_valid ? head_type : '0;
  assign illegal_o   = head_valid & head_ill;
  assign imm_sel_o   = type_o[TYPE_W-1:1];

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: data registers are reset too, since out_inst_o/out_pc_o must read 0 after reset.
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head_inst  <= '0;
      head_pc    <= '0;
      head_type  <= '0;
      head_ill   <= 1'b0;
      skid_inst  <= '0;
      skid_pc    <= '0;
      skid_type  <= '0;
      skid_ill   <= 1'b0;
    end else if (flush_i) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (enq) begin
          head_valid <= 1'b1;
          {head_inst, head_pc, head_type, head_ill} <= {in_inst_i, in_pc_i, in_type, in_ill};
        end
        ONE: begin
          if (enq && deq) begin
            {head_inst, head_pc, head_type, head_ill} <= {in_inst_i, in_pc_i, in_type, in_ill};
          end else if (enq) begin
            skid_valid <= 1'b1;
            {skid_inst, skid_pc, skid_type, skid_ill} <= {in_inst_i, in_pc_i, in_type, in_ill};
          end else if (deq) begin
            head_valid <= 1'b0;
          end
        end
        TWO: if (deq) begin
          skid_valid <= 1'b0;
          {head_inst, head_pc, head_type, head_ill} <= {skid_inst, skid_pc, skid_type, skid_ill};
        end
        default: begin
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IDU_PERF_EN
  logic [31:0] issue_cnt, stall_cnt;

  // Flush deliberately does not clear these; a deq in the flush cycle still counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (deq)                       issue_cnt <= issue_cnt + 32'd1;
      if (head_valid && !out_ready_i) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_issue_o = issue_cnt;
  assign perf_stall_o = stall_cnt;
`else
  assign perf_issue_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule
